// File: rtl/camera_power_seq.sv
// Power-up/power-down sequencer for image sensors: drives PWDN/RESETB per camera
// with cycle-accurate delays and hands off to SCCB configuration via initial_en.
module camera_power_seq #(
    parameter int NUM_CAM    = 2,
    parameter int T_PWDN_CYC = 250000,
    parameter int T_RST_CYC  = 65536,
    parameter int T_INIT_CYC = 1048576,
    parameter int T_OFF_CYC  = 1000,
    parameter int CNT_W      = 21
) (
    input  logic               clk_50M,
    input  logic               reset_n,
    input  logic               seq_en,
    input  logic [NUM_CAM-1:0] cam_mask,
    output logic [NUM_CAM-1:0] camera_rstn,
    output logic [NUM_CAM-1:0] camera_pwnd,
    output logic               initial_en,
    output logic               seq_busy,
    output logic [2:0]         seq_state
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PWUP  = 3'd1,
        S_RSTW  = 3'd2,
        S_INITW = 3'd3,
        S_READY = 3'd4,
        S_SHDN  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PWDN_LAST = CNT_W'(T_PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST_CYC - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(T_OFF_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CAM-1:0] mask_q, mask_d;
    logic [NUM_CAM-1:0] pwnd_q, pwnd_d;
    logic [NUM_CAM-1:0] rstn_q, rstn_d;
    logic               init_q, init_d;
    logic               busy_q, busy_d;
    logic               timed;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        timed   = 1'b1;
        case (state_q)
            S_OFF: begin
                timed = 1'b0;
                if (seq_en && (|cam_mask)) begin
                    state_d = S_PWUP;
                    mask_d  = cam_mask;
                end
            end
            S_PWUP: begin
                // Nothing is powered yet, so an abort needs no shutdown phase.
                if (!seq_en)                state_d = S_OFF;
                else if (cnt_q == PWDN_LAST) state_d = S_RSTW;
            end
            S_RSTW: begin
                if (!seq_en)                state_d = S_SHDN;
                else if (cnt_q == RST_LAST)  state_d = S_INITW;
            end
            S_INITW: begin
                if (!seq_en)                state_d = S_SHDN;
                else if (cnt_q == INIT_LAST) state_d = S_READY;
            end
            S_READY: begin
                timed = 1'b0;
                if (!seq_en) state_d = S_SHDN;
            end
            S_SHDN: begin
                if (cnt_q == OFF_LAST) state_d = S_OFF;
            end
            default: begin
                timed   = 1'b0;
                state_d = S_OFF;
            end
        endcase

        cnt_d = (state_d != state_q || !timed) ? '0 : cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so they register in step with it.
        pwnd_d = '1;
        rstn_d = '0;
        init_d = 1'b0;
        busy_d = 1'b1;
        case (state_d)
            S_OFF:   busy_d = 1'b0;
            S_PWUP:  ;
            S_RSTW:  pwnd_d = ~mask_d;
            S_INITW: begin
                pwnd_d = ~mask_d;
                rstn_d = mask_d;
            end
            S_READY: begin
                pwnd_d = ~mask_d;
                rstn_d = mask_d;
                init_d = 1'b1;
                busy_d = 1'b0;
            end
            S_SHDN:  pwnd_d = ~mask_d;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            mask_q  <= '0;
            pwnd_q  <= '1;
            rstn_q  <= '0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            pwnd_q  <= pwnd_d;
            rstn_q  <= rstn_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
        end
    end

    assign camera_pwnd = pwnd_q;
    assign camera_rstn = rstn_q;
    assign initial_en  = init_q;
    assign seq_busy    = busy_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_camera_power_seq.sv
// Bench for camera_power_seq: fixed vector table, corner sequences and random
// stimulus compared against an event-timestamp reference model.
module tb_camera_power_seq;

    localparam int TP = 5;
    localparam int TR = 3;
    localparam int TI = 4;
    localparam int TO = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       seq_en = 1'b0;
    logic [1:0] cam_mask = 2'b00;
    logic [1:0] camera_rstn, camera_pwnd;
    logic       initial_en, seq_busy;
    logic [2:0] seq_state;
    logic [8:0] dut_out;

    int tests = 0;
    int fails = 0;

    camera_power_seq #(
        .NUM_CAM(2), .T_PWDN_CYC(TP), .T_RST_CYC(TR),
        .T_INIT_CYC(TI), .T_OFF_CYC(TO), .CNT_W(4)
    ) dut (
        .clk_50M(clk), .reset_n(reset_n), .seq_en(seq_en), .cam_mask(cam_mask),
        .camera_rstn(camera_rstn), .camera_pwnd(camera_pwnd),
        .initial_en(initial_en), .seq_busy(seq_busy), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    // {pwnd[1:0], rstn[1:0], initial_en, seq_busy, seq_state[2:0]}
    assign dut_out = {camera_pwnd, camera_rstn, initial_en, seq_busy, seq_state};

    // Reference model: remembers when the power-up and shutdown began and
    // derives the visible phase from elapsed edges.
    int         e_cnt;
    bit         on, dn;
    int         k, j;
    logic [1:0] m;

    function automatic void model_reset();
        e_cnt = -1; on = 0; dn = 0; k = 0; j = 0; m = 2'b00;
    endfunction

    function automatic void model_edge(input logic s, input logic [1:0] cm);
        e_cnt++;
        if (dn) begin
            if (e_cnt - j >= TO) dn = 0;
        end else if (on) begin
            if (!s) begin
                on = 0;
                if (e_cnt - k > TP) begin
                    dn = 1;
                    j  = e_cnt;
                end
            end
        end else if (s && cm != 2'b00) begin
            on = 1; k = e_cnt; m = cm;
        end
    endfunction

    function automatic logic [8:0] model_out();
        int d;
        if (dn) return {~m, 2'b00, 1'b0, 1'b1, 3'd5};
        if (!on) return {2'b11, 2'b00, 1'b0, 1'b0, 3'd0};
        d = e_cnt - k;
        if (d < TP)           return {2'b11, 2'b00, 1'b0, 1'b1, 3'd1};
        if (d < TP + TR)      return {~m, 2'b00, 1'b0, 1'b1, 3'd2};
        if (d < TP + TR + TI) return {~m, m, 1'b0, 1'b1, 3'd3};
        return {~m, m, 1'b1, 1'b0, 3'd4};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s edge %0d: got %b required %b (pwnd,rstn,ie,busy,state)",
                     name, e_cnt, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic [1:0] cm);
        seq_en   = s;
        cam_mask = cm;
        @(posedge clk);
        model_edge(s, cm);
        #1;
        check("model", dut_out, model_out());
    endtask

    localparam logic [8:0] RESET_VAL = {2'b11, 2'b00, 1'b0, 1'b0, 3'd0};

    task automatic do_reset();
        seq_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("reset_async", dut_out, RESET_VAL);
        @(negedge clk);
        check("reset_hold", dut_out, RESET_VAL);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct packed {
        logic       s;
        logic [1:0] m;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t vec(input logic s, input logic [1:0] mm, input logic [8:0] e);
        vec_t v;
        v.s = s; v.m = mm; v.exp = e;
        return v;
    endfunction

    initial begin
        logic s_r;
        tbl[0]  = vec(1, 2'b11, {2'b11, 2'b00, 1'b0, 1'b1, 3'd1});
        tbl[1]  = vec(1, 2'b11, {2'b11, 2'b00, 1'b0, 1'b1, 3'd1});
        tbl[2]  = vec(1, 2'b11, {2'b11, 2'b00, 1'b0, 1'b1, 3'd1});
        tbl[3]  = vec(1, 2'b11, {2'b11, 2'b00, 1'b0, 1'b1, 3'd1});
        tbl[4]  = vec(1, 2'b11, {2'b11, 2'b00, 1'b0, 1'b1, 3'd1});
        tbl[5]  = vec(1, 2'b11, {2'b00, 2'b00, 1'b0, 1'b1, 3'd2});
        tbl[6]  = vec(1, 2'b11, {2'b00, 2'b00, 1'b0, 1'b1, 3'd2});
        tbl[7]  = vec(1, 2'b11, {2'b00, 2'b00, 1'b0, 1'b1, 3'd2});
        tbl[8]  = vec(1, 2'b11, {2'b00, 2'b11, 1'b0, 1'b1, 3'd3});
        tbl[9]  = vec(1, 2'b11, {2'b00, 2'b11, 1'b0, 1'b1, 3'd3});
        tbl[10] = vec(1, 2'b11, {2'b00, 2'b11, 1'b0, 1'b1, 3'd3});
        tbl[11] = vec(1, 2'b11, {2'b00, 2'b11, 1'b0, 1'b1, 3'd3});
        tbl[12] = vec(1, 2'b11, {2'b00, 2'b11, 1'b1, 1'b0, 3'd4});
        tbl[13] = vec(1, 2'b11, {2'b00, 2'b11, 1'b1, 1'b0, 3'd4});
        tbl[14] = vec(1, 2'b11, {2'b00, 2'b11, 1'b1, 1'b0, 3'd4});
        tbl[15] = vec(0, 2'b11, {2'b00, 2'b00, 1'b0, 1'b1, 3'd5});
        tbl[16] = vec(0, 2'b11, {2'b00, 2'b00, 1'b0, 1'b1, 3'd5});
        tbl[17] = vec(0, 2'b11, {2'b11, 2'b00, 1'b0, 1'b0, 3'd0});

        model_reset();
        #2;
        do_reset();

        // Basic power-up and shutdown from ready.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].s, tbl[i].m);
            check("table", dut_out, tbl[i].exp);
        end

        // Partial mask; later mask change must be ignored.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, (i < 3) ? 2'b01 : 2'b10);
            check("cam1_idle", {camera_pwnd[1], camera_rstn[1]}, 9'b10);
        end
        check("partial_ready", dut_out, {2'b10, 2'b01, 1'b1, 1'b0, 3'd4});
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11);

        // Abort in power-up and restart.
        do_reset();
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        step(1'b0, 2'b11);
        check("abort_pwup", dut_out, RESET_VAL);
        step(1'b0, 2'b11);
        for (int i = 4; i <= 16; i++) begin
            step(1'b1, 2'b11);
            if (i == 15) check("restart_ie_low", {8'd0, initial_en}, 9'd0);
        end
        check("restart_ie_high", {8'd0, initial_en}, 9'd1);

        // Abort in S_INITW, seq_en re-raised during shutdown.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 2'b11);
        check("in_initw", {6'd0, seq_state}, 9'd3);
        step(1'b0, 2'b11);
        step(1'b1, 2'b11);
        check("shdn_ignores_en", {6'd0, seq_state}, 9'd5);
        step(1'b1, 2'b11);
        check("shdn_to_off", dut_out, RESET_VAL);
        step(1'b1, 2'b11);
        check("restart_after_shdn", {6'd0, seq_state}, 9'd1);

        // Zero mask never leaves S_OFF.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00);
        check("mask_zero", dut_out, RESET_VAL);

        // Asynchronous reset in the middle of S_RSTW.
        for (int i = 0; i < 6; i++) step(1'b1, 2'b11);
        check("pre_async_rstw", {6'd0, seq_state}, 9'd2);
        #2;
        do_reset();

        // Randomised run against the model.
        s_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) s_r = ~s_r;
            step(s_r, 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/camera_power_seq.md
# camera_power_seq

Parametrised power-up/power-down sequencer for one or more image sensors sharing a clock domain. It generates per-camera PWDN and RESETB strobes with programmable cycle-accurate delays and releases `initial_en` to the SCCB configuration block. It also supports an orderly power-down and re-power under control of a level enable. It sits between board reset and the SCCB init master in the camera capture path.

## Interface
- `NUM_CAM`, 2: number of sensors driven; width of the mask and pin vectors (≥1).
- `T_PWDN_CYC`, 250000: cycles PWDN is held high after sequence start (5 ms at 50 MHz); ≥1.
- `T_RST_CYC`, 65536: cycles from PWDN low to RESETB high (1.3 ms); ≥1.
- `T_INIT_CYC`, 1048576: cycles from RESETB high to `initial_en` (21 ms); ≥1.
- `T_OFF_CYC`, 1000: cycles RESETB is held low before PWDN is raised on shutdown; ≥1.
- `CNT_W`, 21: delay counter width. Must hold max(T_*)−1.

Ports:
- `clk_50M` in 1: the single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `seq_en` in 1: level request. 1 = power up / stay up; 0 = power down / stay down.
- `cam_mask` in NUM_CAM: cameras to power; sampled only when a sequence starts.
- `camera_rstn` out NUM_CAM: RESETB per camera, active low.
- `camera_pwnd` out NUM_CAM: PWDN per camera, active high.
- `initial_en` out 1: high while sensors are ready for SCCB configuration.
- `seq_busy` out 1: high in any state other than S_OFF and S_READY.
- `seq_state` out 3: current state encoding, for debug.

## Operation
- States and encodings: S_OFF=0, S_PWUP=1, S_RSTW=2, S_INITW=3, S_READY=4, S_SHDN=5. Codes 6–7 are unreachable and recover to S_OFF.
- Reset state: S_OFF. All outputs are registered with these reset values:
  - `camera_pwnd` = all 1
  - `camera_rstn` = all 0
  - `initial_en` = 0, `seq_busy` = 0, `seq_state` = 0
  - internal `mask_q` = 0, counter = 0
- S_OFF:
  - Outputs: pwnd all 1, rstn all 0.
  - If `seq_en`=1 and `cam_mask`≠0: latch `mask_q`←`cam_mask` and go to S_PWUP.
  - If `seq_en`=1 and `cam_mask`=0: stay in S_OFF.
- S_PWUP:
  - Outputs: pwnd all 1, rstn all 0.
  - On `seq_en`=0, go straight to S_OFF (no sensor powered yet).
  - Otherwise go to S_RSTW after T_PWDN_CYC cycles.
- S_RSTW:
  - Outputs: pwnd=~mask_q, rstn all 0.
  - On `seq_en`=0, go to S_SHDN.
  - Otherwise go to S_INITW after T_RST_CYC cycles.
- S_INITW:
  - Outputs: pwnd=~mask_q, rstn=mask_q.
  - On `seq_en`=0, go to S_SHDN.
  - Otherwise go to S_READY after T_INIT_CYC cycles.
- S_READY:
  - Outputs: pwnd=~mask_q, rstn=mask_q, `initial_en`=1.
  - On `seq_en`=0, go to S_SHDN.
- S_SHDN:
  - Outputs: rstn all 0, pwnd=~mask_q, `initial_en`=0.
  - After T_OFF_CYC cycles: go to S_OFF, where pwnd returns to all 1.
  - `seq_en` is ignored until S_OFF is reached. If `seq_en` is still 1 in S_OFF, a new sequence starts on the next edge with a fresh mask sample.
- Masked-out cameras (mask_q bit 0) keep pwnd=1 and rstn=0 in every state.
- `cam_mask` changes after the start of a sequence have no effect.
- Counter rules:
  - Cleared to 0 on every state entry and incremented each cycle in a timed state.
  - Transition occurs on the edge where counter == T−1.
  - No wrap-around is possible when CNT_W is sized correctly.
- `seq_en` is assumed synchronous to `clk_50M`. Synchronising it is the caller's job.

## Timing
- Take `seq_en`=1 sampled at edge k (in S_OFF, mask≠0). Then:
  - S_PWUP is visible after edge k.
  - pwnd falls after edge k+T_PWDN_CYC.
  - rstn rises after edge k+T_PWDN_CYC+T_RST_CYC.
  - `initial_en` rises after edge k+T_PWDN_CYC+T_RST_CYC+T_INIT_CYC.
- Take `seq_en`=0 sampled at edge j in S_RSTW, S_INITW or S_READY. Then:
  - rstn all 0 and `initial_en`=0 after edge j.
  - pwnd all 1 after edge j+T_OFF_CYC.
- `seq_en`=0 sampled at edge j in S_PWUP gives S_OFF after edge j; outputs are unchanged.
- A `reset_n` assertion at any time forces reset values immediately, without waiting for a clock edge. This includes mid-sequence and in S_SHDN.
- Release of `reset_n` is taken as synchronous. The first sample of `seq_en` happens at the first edge after release.
- Throughput: a full up/down cycle is T_PWDN+T_RST+T_INIT+T_OFF cycles minimum.

## Test plan
Parameters for all scenarios: NUM_CAM=2, T_PWDN_CYC=5, T_RST_CYC=3, T_INIT_CYC=4, T_OFF_CYC=2.
- Basic power-up: mask=2'b11, `seq_en` high at edge 0 -> pwnd=00 after edge 5; rstn=11 after edge 8; `initial_en`=1 after edge 12; `seq_busy` high after edges 0–11 and low after edge 12.
- Partial mask: mask=2'b01 -> camera1 holds pwnd=1 and rstn=0 throughout; camera0 follows the basic power-up timing. A mask change to 2'b10 at edge 3 has no effect.
- Shutdown from ready: drop `seq_en` at edge 15 -> rstn=00 and `initial_en`=0 after edge 15; pwnd=11 after edge 17; `seq_state`=0.
- Abort and restart: drop `seq_en` at edge 2 (S_PWUP) -> S_OFF after edge 2. Raise it at edge 4 -> `initial_en` after edge 16.
- Abort in S_INITW with `seq_en` re-raised during S_SHDN -> S_SHDN runs its full 2 cycles, then S_OFF, and a new sequence starts on the next edge.
- Mask zero and async reset: `seq_en`=1 with mask=0 -> stays in S_OFF. Assert `reset_n`=0 mid S_RSTW between edges -> outputs reach reset values before the next edge.
